// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply scheduler.
// Holds the element width, the FSM state encoding and the index width helper.
package matmul_pkg;

   localparam int ELEM_WIDTH = 32;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT_IP = 3'd2,
      S_EMIT    = 3'd3,
      S_FINISH  = 3'd4
   } state_e;

   // A dimension of 1 still needs a 1-bit select that simply stays 0.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matmul_index_counter.sv
// Row-major (row, col) walker over the result matrix.
// Clear wins over advance; advancing past the last element wraps to (0,0).
module matmul_index_counter
   import matmul_pkg::*;
#(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   localparam int RW  = idx_width(ROWS),
   localparam int CW  = idx_width(COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          adv_i,
   output logic [RW-1:0] row_o,
   output logic [CW-1:0] col_o,
   output logic          last_o
);

   logic [RW-1:0] row_q;
   logic [CW-1:0] col_q;
   logic          row_last;
   logic          col_last;

   assign row_last = (row_q == RW'(ROWS - 1));
   assign col_last = (col_q == CW'(COLS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else if (clr_i) begin
         row_q <= '0;
         col_q <= '0;
      end else if (adv_i) begin
         if (col_last) begin
            col_q <= '0;
            row_q <= row_last ? '0 : row_q + 1'b1;
         end else begin
            col_q <= col_q + 1'b1;
         end
      end
   end

   assign row_o  = row_q;
   assign col_o  = col_q;
   assign last_o = row_last && col_last;

endmodule

// File: rtl/matmul_scheduler.sv
// Walks one shared inner_product unit over every element of the result matrix
// and streams each result with its coordinates over a valid/ready port.
module matmul_scheduler
   import matmul_pkg::*;
#(
   parameter int ROWS    = 4,
   parameter int COLS    = 4,
   parameter int TIMEOUT = 1024,
   localparam int RW     = idx_width(ROWS),
   localparam int CW     = idx_width(COLS),
   localparam int TW     = $clog2(TIMEOUT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [RW-1:0]         row_idx,
   output logic [CW-1:0]         col_idx,
   output logic                  ip_start,
   input  logic                  ip_done,
   input  logic [ELEM_WIDTH-1:0] ip_result,
   output logic                  ip_ack,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [ELEM_WIDTH-1:0] res_data,
   output logic [RW-1:0]         res_row,
   output logic [CW-1:0]         res_col
);

   state_e                state_q;
   logic [TW-1:0]         tmo_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  err_q;
   logic                  ip_start_q;
   logic                  ip_ack_q;
   logic                  res_valid_q;
   logic [ELEM_WIDTH-1:0] res_data_q;
   logic [RW-1:0]         res_row_q;
   logic [CW-1:0]         res_col_q;

   logic                  accept;
   logic                  handshake;
   logic                  cnt_last;

   assign accept    = (state_q == S_IDLE) && start && !abort;
   // An aborted handshake still counts as delivered, so the indices move on.
   assign handshake = (state_q == S_EMIT) && res_valid_q && res_ready;

   matmul_index_counter #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_idx (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (accept),
      .adv_i  (handshake),
      .row_o  (row_idx),
      .col_o  (col_idx),
      .last_o (cnt_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         tmo_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ip_start_q  <= 1'b0;
         ip_ack_q    <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_row_q   <= '0;
         res_col_q   <= '0;
      end else begin
         ip_start_q <= 1'b0;
         ip_ack_q   <= 1'b0;
         done_q     <= 1'b0;
         if (abort && (state_q != S_IDLE)) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (accept) begin
                     err_q   <= 1'b0;
                     busy_q  <= 1'b1;
                     state_q <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  ip_start_q <= 1'b1;
                  tmo_q      <= '0;
                  state_q    <= S_WAIT_IP;
               end
               S_WAIT_IP: begin
                  // A result arriving on the timeout cycle is still taken.
                  if (ip_done) begin
                     res_data_q  <= ip_result;
                     res_row_q   <= row_idx;
                     res_col_q   <= col_idx;
                     ip_ack_q    <= 1'b1;
                     res_valid_q <= 1'b1;
                     state_q     <= S_EMIT;
                  end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     tmo_q <= tmo_q + 1'b1;
                  end
               end
               S_EMIT: begin
                  if (res_ready) begin
                     res_valid_q <= 1'b0;
                     if (cnt_last) begin
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                     end else begin
                        state_q <= S_ISSUE;
                     end
                  end
               end
               S_FINISH: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign ip_start  = ip_start_q;
   assign ip_ack    = ip_ack_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_row   = res_row_q;
   assign res_col   = res_col_q;

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler on a 2x2 matrix with a short timeout,
// driving a behavioural inner_product that answers 5 cycles after ip_start.
module tb_matmul_scheduler;

   localparam int ROWS    = 2;
   localparam int COLS    = 2;
   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        res_ready = 1'b1;
   logic        ip_done;
   logic [31:0] ip_result;
   logic        busy, done, err, ip_start, ip_ack, res_valid;
   logic        row_idx, col_idx, res_row, res_col;
   logic [31:0] res_data;

   int n_chk = 0;
   int n_err = 0;
   int n_start = 0, n_ack = 0, n_done = 0;
   int q_row[$];
   int q_col[$];
   logic [31:0] q_data[$];

   logic model_en = 1'b1;
   logic pend;
   int   dly;

   always #5 clk = ~clk;

   matmul_scheduler #(
      .ROWS    (ROWS),
      .COLS    (COLS),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .row_idx   (row_idx),
      .col_idx   (col_idx),
      .ip_start  (ip_start),
      .ip_done   (ip_done),
      .ip_result (ip_result),
      .ip_ack    (ip_ack),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_row   (res_row),
      .res_col   (res_col)
   );

   // inner_product model: result = row*16 + col, done held until acked
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ip_done   <= 1'b0;
         ip_result <= '0;
         pend      <= 1'b0;
         dly       <= 0;
      end else if (abort && busy) begin
         ip_done <= 1'b0;
         pend    <= 1'b0;
      end else begin
         if (ip_ack) ip_done <= 1'b0;
         if (ip_start && model_en) begin
            pend <= 1'b1;
            dly  <= 4;
         end else if (pend) begin
            if (dly == 0) begin
               ip_done   <= 1'b1;
               ip_result <= 32'(row_idx) * 32'd16 + 32'(col_idx);
               pend      <= 1'b0;
            end else begin
               dly <= dly - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (ip_start) n_start <= n_start + 1;
         if (ip_ack)   n_ack   <= n_ack + 1;
         if (done)     n_done  <= n_done + 1;
         if (res_valid && res_ready) begin
            q_row.push_back(int'(res_row));
            q_col.push_back(int'(res_col));
            q_data.push_back(res_data);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int target, input string tag);
      int k = 0;
      while (n_done < target && k < 300) begin
         at_neg();
         k++;
      end
      chk(tag, 32'(n_done), 32'(target));
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      at_neg();
      while (!res_valid && k < 100) begin
         at_neg();
         k++;
      end
      chk(tag, 32'(res_valid), 32'd1);
   endtask

   task automatic check_results(input string tag);
      chk({tag, "_count"}, 32'(q_data.size()), 32'd4);
      for (int i = 0; i < 4 && i < q_data.size(); i++) begin
         chk($sformatf("%s_row%0d", tag, i), 32'(q_row[i]), 32'(i / 2));
         chk($sformatf("%s_col%0d", tag, i), 32'(q_col[i]), 32'(i % 2));
         chk($sformatf("%s_data%0d", tag, i), q_data[i], 32'((i / 2) * 16 + (i % 2)));
      end
   endtask

   initial begin
      int b_start, b_ack, b_done, s, k;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      at_neg();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ip_start", 32'(ip_start), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_idx", {30'd0, row_idx, col_idx}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // full pass, ready always high, start-to-ip_start latency
      b_start = n_start; b_ack = n_ack; b_done = n_done;
      q_row.delete(); q_col.delete(); q_data.delete();
      drive_start();
      at_neg();
      chk("lat_busy_n1", 32'(busy), 32'd1);
      chk("lat_ip_start_n1", 32'(ip_start), 32'd0);
      at_neg();
      chk("lat_ip_start_n2", 32'(ip_start), 32'd1);
      wait_done(b_done + 1, "p1_done");
      at_neg();
      chk("p1_busy_after", 32'(busy), 32'd0);
      chk("p1_done_width", 32'(n_done - b_done), 32'd1);
      chk("p1_ip_starts", 32'(n_start - b_start), 32'd4);
      chk("p1_ip_acks", 32'(n_ack - b_ack), 32'd4);
      check_results("p1");

      // res_ready stall on the second element
      res_ready = 1'b0;
      b_done = n_done;
      q_row.delete(); q_col.delete(); q_data.delete();
      drive_start();
      wait_valid("st_valid0");
      @(posedge clk); #1 res_ready = 1'b1;
      @(posedge clk); #1 res_ready = 1'b0;
      wait_valid("st_valid1");
      s = n_start;
      for (int i = 0; i < 10; i++) begin
         at_neg();
         chk("st_hold_valid", 32'(res_valid), 32'd1);
         chk("st_hold_data", res_data, 32'h1);
      end
      chk("st_no_issue", 32'(n_start), 32'(s));
      @(posedge clk); #1 res_ready = 1'b1;
      wait_done(b_done + 1, "st_done");
      check_results("st");

      // timeout: model silent
      at_neg();
      @(posedge clk); #1 model_en = 1'b0;
      b_ack = n_ack; b_done = n_done;
      drive_start();
      at_neg();
      at_neg();
      chk("to_ip_start", 32'(ip_start), 32'd1);
      k = 0;
      while (!err && k < 30) begin
         at_neg();
         k++;
      end
      chk("to_cycles", 32'(k), 32'd8);
      chk("to_busy", 32'(busy), 32'd0);
      repeat (3) at_neg();
      chk("to_err_sticky", 32'(err), 32'd1);
      chk("to_no_done", 32'(n_done - b_done), 32'd0);
      chk("to_no_ack", 32'(n_ack - b_ack), 32'd0);
      @(posedge clk); #1 model_en = 1'b1;
      q_row.delete(); q_col.delete(); q_data.delete();
      drive_start();
      at_neg();
      chk("to_err_cleared", 32'(err), 32'd0);
      wait_done(b_done + 1, "to_done");
      check_results("to");

      // abort during WAIT_IP of (1,0)
      at_neg();
      b_done = n_done;
      drive_start();
      k = 0;
      while (!(ip_start && row_idx && !col_idx) && k < 200) begin
         at_neg();
         k++;
      end
      chk("ab_reach", 32'(ip_start && row_idx && !col_idx), 32'd1);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      at_neg();
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_res_valid", 32'(res_valid), 32'd0);
      b_ack = n_ack;
      repeat (10) at_neg();
      chk("ab_no_ack", 32'(n_ack - b_ack), 32'd0);
      chk("ab_no_done", 32'(n_done - b_done), 32'd0);
      q_row.delete(); q_col.delete(); q_data.delete();
      drive_start();
      at_neg();
      at_neg();
      chk("ab_restart_ip", 32'(ip_start), 32'd1);
      chk("ab_restart_idx", {30'd0, row_idx, col_idx}, 32'd0);
      wait_done(b_done + 1, "ab_done");
      check_results("ab");

      // start with abort in IDLE, then start while busy
      at_neg();
      @(posedge clk); #1 start = 1'b1; abort = 1'b1;
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      at_neg();
      chk("sa_busy", 32'(busy), 32'd0);
      at_neg();
      chk("sa_ip_start", 32'(ip_start), 32'd0);
      b_start = n_start; b_done = n_done;
      q_row.delete(); q_col.delete(); q_data.delete();
      drive_start();
      k = 0;
      while (n_start - b_start < 2 && k < 200) begin
         at_neg();
         k++;
      end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(b_done + 1, "sb_done");
      at_neg();
      chk("sb_ip_starts", 32'(n_start - b_start), 32'd4);
      chk("sb_busy", 32'(busy), 32'd0);
      check_results("sb");

      // asynchronous reset while holding a result in EMIT
      res_ready = 1'b0;
      drive_start();
      wait_valid("ar_valid");
      rst = 1'b1;
      #1;
      chk("ar_res_valid", 32'(res_valid), 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_res_data", res_data, 32'd0);
      chk("ar_err", 32'(err), 32'd0);
      chk("ar_ip_ack", 32'(ip_ack), 32'd0);
      #2 rst = 1'b0;
      res_ready = 1'b1;
      repeat (2) at_neg();
      chk("ar_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/matmul_scheduler.md
Name: matmul_scheduler

Overview:
- Sequences one shared inner_product unit over every element of a ROWS x COLS result matrix.
- Drives row/column selects to external operand muxes and issues the start/done/ack handshake to the unit.
- Streams each 32-bit result out with its coordinates over a valid/ready port.
- Sits between the top-level matrix multiplier control and the inner_product datapath.

Parameters:
- ROWS, 4, result matrix row count (>=1)
- COLS, 4, result matrix column count (>=1)
- TIMEOUT, 1024, max cycles to wait for ip_done before flagging an error (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin full matrix pass; sampled only in IDLE
- abort  in  1  synchronous abort, returns to IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last element accepted
- err  out  1  sticky timeout flag, cleared on accepted start
- row_idx  out  max(1,$clog2(ROWS))  current row select to operand mux
- col_idx  out  max(1,$clog2(COLS))  current column select to operand mux
- ip_start  out  1  one-cycle start pulse to inner_product
- ip_done  in  1  inner_product result ready (level)
- ip_result  in  32  inner_product result, valid while ip_done
- ip_ack  out  1  one-cycle acknowledge of captured result
- res_valid  out  1  result stream valid
- res_ready  in  1  result stream ready
- res_data  out  32  result element
- res_row, res_col  out  as row_idx/col_idx  coordinates of res_data

Behaviour:
- Reset values: all outputs 0; state IDLE; internal timeout counter 0.
- All outputs registered. States: IDLE, ISSUE, WAIT_IP, EMIT, FINISH.
- IDLE: on start=1 (abort=0), set row_idx=col_idx=0, clear err, go to ISSUE. Start in any other state is ignored.
- ISSUE: ip_start=1 for exactly one cycle; load timeout counter to 0; go to WAIT_IP. row_idx/col_idx must be stable at least one cycle before ip_start rises (guaranteed: set on entry to ISSUE).
- WAIT_IP: counter increments each cycle.
  - On ip_done=1: capture ip_result into res_data, copy indices into res_row/res_col, ip_ack=1 for one cycle, go to EMIT.
  - If counter reaches TIMEOUT-1 without ip_done: set err=1, no ack, go to IDLE (done not pulsed).
  - ip_done and timeout in the same cycle: ip_done wins.
- EMIT: res_valid=1 and held, with res_data/res_row/res_col stable, until res_ready=1.
  - On the handshake cycle: res_valid drops next cycle and indices advance.
  - Index advance: col_idx+1; if col_idx==COLS-1 then col_idx=0 and row_idx+1.
  - After the last element (ROWS-1, COLS-1): go to FINISH with indices wrapping to 0. Otherwise go to ISSUE.
- FINISH: done=1 for one cycle, then IDLE.
- Latency: start cycle N gives ip_start at N+2. Minimum per-element cost is 3 cycles plus the unit's latency plus any res_ready stall.
- abort=1 in any non-IDLE state: next state IDLE; ip_start, ip_ack, res_valid and done deasserted; err unchanged. An abort in the same cycle as a res handshake still aborts; the element counts as delivered.
- ROWS=1 or COLS=1 is legal; indices of width 1 stay 0.
- rst mid-operation: immediate return to reset values, including err.
- busy=1 from the cycle after start acceptance through the FINISH cycle inclusive.

Decomposition:
- matmul_pkg: ELEM_WIDTH=32, state enum encoding, index width function.
- One sub-module, matmul_index_counter: row/column counter with clear, advance, wrap, and a last flag. It is instantiated once.

Test Plan:
- ROWS=COLS=2; start; model answers ip_done 5 cycles after each ip_start with ip_result=row*16+col, res_ready=1 → four results in order (0,0)=0x0, (0,1)=0x1, (1,0)=0x10, (1,1)=0x11; exactly 4 ip_start and 4 ip_ack pulses; one done pulse; busy low afterwards.
- Same setup, res_ready held low 10 cycles on the second element → res_valid and res_data=0x1 stable throughout; no new ip_start until that handshake completes.
- TIMEOUT=8; model never asserts ip_done → err=1 eight cycles after ip_start; state IDLE; no done; the next start clears err.
- abort asserted during WAIT_IP of element (1,0) → IDLE next cycle; no ip_ack or done; busy=0; a later start restarts at (0,0).
- start pulsed while busy, and start asserted together with abort in IDLE → both ignored; element sequence unchanged.
- rst asserted mid-EMIT (asynchronous, between clock edges) → all outputs 0 immediately; err=0.
